// File: rtl/serial_mag_cmp_pkg.sv
// Shared types and slice-result encodings for the serial magnitude comparator.
package serial_mag_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // One-hot {eq, gt, lt}
    typedef logic [2:0] cmp_res_t;

    localparam cmp_res_t RES_EQ = 3'b100;
    localparam cmp_res_t RES_GT = 3'b010;
    localparam cmp_res_t RES_LT = 3'b001;

endpackage

// File: rtl/serial_mag_cmp_digit_cmp.sv
// Combinational 2-bit digit comparator; word_i = {a_digit, b_digit}.
module digit_cmp
    import serial_mag_cmp_pkg::*;
(
    input  logic [3:0] word_i,
    output cmp_res_t   res_o
);

    logic [1:0] a_dig;
    logic [1:0] b_dig;

    assign a_dig = word_i[3:2];
    assign b_dig = word_i[1:0];

    always_comb begin
        res_o = RES_EQ;
        if (a_dig > b_dig)      res_o = RES_GT;
        else if (a_dig < b_dig) res_o = RES_LT;
    end

endmodule

// File: rtl/serial_mag_cmp.sv
// MSB-first serial magnitude comparator, one 2-bit digit per cycle.
// SERIAL_MAG_CMP_EARLY_EXIT_EN: stop at the first differing digit instead of a fixed DIGITS-cycle scan.
module serial_mag_cmp
    import serial_mag_cmp_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic             busy
);

    localparam int DIGITS = WIDTH / 2;
    localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    localparam logic [WIDTH-1:0] MSB_MASK = SIGNED ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    cmp_res_t         res_q, res_d;
    cmp_res_t         slice_res;

    digit_cmp u_slice (
        .word_i ({a_sh_q[WIDTH-1 -: 2], b_sh_q[WIDTH-1 -: 2]}),
        .res_o  (slice_res)
    );

`ifndef SERIAL_MAG_CMP_EARLY_EXIT_EN
    // First non-eq digit result; stays RES_EQ until a differing digit is recorded.
    cmp_res_t sticky_q, sticky_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sticky_q <= '0;
        else          sticky_q <= sticky_d;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
`ifndef SERIAL_MAG_CMP_EARLY_EXIT_EN
        sticky_d = sticky_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_sh_d   = a ^ MSB_MASK;
                    b_sh_d   = b ^ MSB_MASK;
                    cnt_d    = CW'(DIGITS - 1);
`ifndef SERIAL_MAG_CMP_EARLY_EXIT_EN
                    sticky_d = RES_EQ;
`endif
                    state_d  = SCAN;
                end
            end
            SCAN: begin
`ifdef SERIAL_MAG_CMP_EARLY_EXIT_EN
                if (slice_res != RES_EQ) begin
                    res_d   = slice_res;
                    state_d = DONE;
                end else if (cnt_q == '0) begin
                    res_d   = RES_EQ;
                    state_d = DONE;
                end else begin
                    a_sh_d = a_sh_q << 2;
                    b_sh_d = b_sh_q << 2;
                    cnt_d  = cnt_q - 1'b1;
                end
`else
                if (sticky_q == RES_EQ && slice_res != RES_EQ)
                    sticky_d = slice_res;
                if (cnt_q == '0) begin
                    res_d   = (sticky_q == RES_EQ) ? slice_res : sticky_q;
                    state_d = DONE;
                end else begin
                    a_sh_d = a_sh_q << 2;
                    b_sh_d = b_sh_q << 2;
                    cnt_d  = cnt_q - 1'b1;
                end
`endif
            end
            DONE: begin
                if (done_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign start_ready  = (state_q == IDLE);
    assign done_valid   = (state_q == DONE);
    assign busy         = (state_q != IDLE);
    assign {eq, gt, lt} = res_q;

endmodule

// File: tb/tb_serial_mag_cmp.sv
// Scoreboard bench: stimulus pushes expected results, a monitor pops them on done_valid.
module tb_serial_mag_cmp;
    import serial_mag_cmp_pkg::*;

    typedef struct {
        cmp_res_t res;
        int       lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [1:0]       sv, sr, dv, dr, bsy, eqo, gto, lto;
    logic [1:0][15:0] av, bv;

    exp_t q0[$];
    exp_t q1[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   acc[2];
    bit   seen[2];

    always #5 clk = ~clk;

    // Instance 0 unsigned, instance 1 signed
    serial_mag_cmp #(.WIDTH(16), .SIGNED(1'b0)) u_dut_u (
        .clk(clk), .reset_n(reset_n), .start_valid(sv[0]), .start_ready(sr[0]),
        .a(av[0]), .b(bv[0]), .done_valid(dv[0]), .done_ready(dr[0]),
        .eq(eqo[0]), .gt(gto[0]), .lt(lto[0]), .busy(bsy[0])
    );

    serial_mag_cmp #(.WIDTH(16), .SIGNED(1'b1)) u_dut_s (
        .clk(clk), .reset_n(reset_n), .start_valid(sv[1]), .start_ready(sr[1]),
        .a(av[1]), .b(bv[1]), .done_valid(dv[1]), .done_ready(dr[1]),
        .eq(eqo[1]), .gt(gto[1]), .lt(lto[1]), .busy(bsy[1])
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic int exp_lat(input int k);
`ifdef SERIAL_MAG_CMP_EARLY_EXIT_EN
        return k + 1;
`else
        return 9;
`endif
    endfunction

    // Monitor: latency measured from the handshake cycle to first done_valid cycle
    always @(negedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (!reset_n) begin
                seen[d] = 1'b0;
            end else begin
                if (sv[d] && sr[d]) acc[d] = cyc;
                if (dv[d] && !seen[d]) begin
                    seen[d] = 1'b1;
                    if ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_result dut%0d: got %b expected none", d,
                                 {eqo[d], gto[d], lto[d]});
                    end else begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("result dut%0d", d), 32'({eqo[d], gto[d], lto[d]}), 32'(e.res));
                        chk($sformatf("latency dut%0d", d), 32'(cyc - acc[d]), 32'(e.lat));
                    end
                end
                if (!dv[d]) seen[d] = 1'b0;
            end
        end
    end

    task automatic issue(input int d, input logic [15:0] a_v, input logic [15:0] b_v,
                         input cmp_res_t r, input int k);
        exp_t e;
        int   n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!sr[d] && n < 50);
        if (n >= 50) chk("timeout_idle", 32'(sr[d]), 32'd1);
        e.res = r;
        e.lat = exp_lat(k);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        av[d] = a_v;
        bv[d] = b_v;
        sv[d] = 1'b1;
        @(posedge clk); #1;
        sv[d] = 1'b0;
    endtask

    task automatic wait_done(input int d);
        int n;
        n = 0;
        while (!dv[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("timeout_done", 32'(dv[d]), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic run(input int d, input logic [15:0] a_v, input logic [15:0] b_v,
                       input cmp_res_t r, input int k);
        issue(d, a_v, b_v, r, k);
        wait_done(d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        sv = '0; dr = '1; av = '0; bv = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst start_ready", 32'(sr[0]), 32'd1);
        chk("rst done_valid", 32'(dv[0]), 32'd0);
        chk("rst busy", 32'(bsy[0]), 32'd0);
        chk("rst eqgtlt", 32'({eqo[0], gto[0], lto[0]}), 32'd0);

        run(0, 16'h1234, 16'h1234, RES_EQ, 8);
        run(0, 16'h8000, 16'h7FFF, RES_GT, 1);
        run(1, 16'h8000, 16'h7FFF, RES_LT, 1);
        run(1, 16'h0001, 16'hFFFF, RES_GT, 1);
        run(0, 16'h0002, 16'h0001, RES_GT, 8);
        run(0, 16'h0001, 16'h0002, RES_LT, 8);
        run(0, 16'h1234, 16'h1235, RES_LT, 8);

        // Backpressure: hold the result while a new start is offered
        dr[0] = 1'b0;
        issue(0, 16'h00F0, 16'h0100, RES_LT, 4);
        for (int n = 0; n < 50 && !dv[0]; n++) @(negedge clk);
        @(posedge clk); #1;
        sv[0] = 1'b1; av[0] = 16'h0003; bv[0] = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall done_valid", 32'(dv[0]), 32'd1);
            chk("stall lt", 32'({eqo[0], gto[0], lto[0]}), 32'(RES_LT));
            chk("stall start_ready", 32'(sr[0]), 32'd0);
        end
        @(posedge clk); #1;
        sv[0] = 1'b0;
        dr[0] = 1'b1;
        @(posedge clk); #1;
        chk("release start_ready", 32'(sr[0]), 32'd1);
        chk("release busy", 32'(bsy[0]), 32'd0);
        chk("release done_valid", 32'(dv[0]), 32'd0);

        // Reset in the middle of a scan discards the pending result
        issue(0, 16'hFFFF, 16'h0000, RES_GT, 1);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst start_ready", 32'(sr[0]), 32'd1);
        chk("midrst done_valid", 32'(dv[0]), 32'd0);
        chk("midrst busy", 32'(bsy[0]), 32'd0);
        chk("midrst eqgtlt", 32'({eqo[0], gto[0], lto[0]}), 32'd0);
        q0.delete();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        run(0, 16'h0001, 16'h0001, RES_EQ, 8);

        repeat (4) @(posedge clk);
        chk("queue0 drained", 32'(q0.size()), 32'd0);
        chk("queue1 drained", 32'(q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_mag_cmp.md
Name: serial_mag_cmp

Overview:
- Multi-cycle unsigned/signed magnitude comparator for two WIDTH-bit operands.
- Scans 2-bit digit pairs MSB-first, one pair per cycle. Each pair forms the 4-bit slice word {a_digit, b_digit}.
- Slice results use the {eq, gt, lt} one-hot encoding of the library's 4-bit comparator.
- Sits downstream of the digit comparator: it consumes slice results and produces the word-level verdict, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16: operand width. Must be even and >= 2. DIGITS = WIDTH/2.
- SIGNED, 0: 1 = two's-complement compare (MSB of each operand inverted before scan); 0 = unsigned.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start_valid  input  1  operands a/b presented
- start_ready  output  1  block can accept operands (IDLE only)
- a  input  WIDTH  left operand, sampled on start handshake
- b  input  WIDTH  right operand, sampled on start handshake
- done_valid  output  1  result valid
- done_ready  input  1  consumer accepts result
- eq  output  1  a == b
- gt  output  1  a > b
- lt  output  1  a < b
- busy  output  1  high in SCAN or DONE

Behaviour:
- One clock. Reset is asynchronous and active-low, on reset_n.
- Reset values:
  - state = IDLE
  - eq = gt = lt = 0
  - done_valid = 0, busy = 0
  - start_ready = 1 (combinational from state == IDLE)
  - shift registers and digit counter = 0
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - Accept when start_valid && start_ready.
  - Load a_sh/b_sh; if SIGNED, MSB inverted.
  - cnt = DIGITS-1; go to SCAN.
- SCAN:
  - Slice input = {a_sh[W-1:W-2], b_sh[W-1:W-2]}.
  - Slice gt or lt: latch {eq,gt,lt} = slice result; go to DONE.
  - Slice eq and cnt == 0: latch 3'b100; go to DONE.
  - Otherwise: shift both registers left by 2; cnt--.
  - start_valid is ignored.
- DONE:
  - done_valid = 1; eq/gt/lt stable and exactly one-hot.
  - When done_ready: go to IDLE, done_valid drops the next cycle.
  - eq/gt/lt keep their last value until the next result is latched.
- Latency: accept edge to done_valid high = k+1 cycles, where k = 1-based position (from MSB) of the first differing digit, or DIGITS if the operands are equal.
- Throughput: one compare per (latency + 1) cycles minimum. No accept in the same cycle as the done handshake.
- Reset asserted mid-SCAN or mid-DONE aborts immediately to the reset values. The pending result is lost.
- done_ready high while not done_valid has no effect.
- WIDTH = 2: a single SCAN cycle.

Optional Feature:
- Macro: SERIAL_MAG_CMP_EARLY_EXIT_EN.
- Defined: early termination at the first differing digit, as above.
- Undefined:
  - SCAN always runs DIGITS cycles; latency is fixed at DIGITS+1.
  - The first non-eq slice result is held in a sticky register.
  - Later slice results are ignored.
  - Final result = sticky value, or eq if none was recorded.

Decomposition:
- Package serial_mag_cmp_pkg holds:
  - state enum typedef (IDLE, SCAN, DONE)
  - cmp_res_t 3-bit typedef
  - constants RES_EQ = 3'b100, RES_GT = 3'b010, RES_LT = 3'b001
- Sub-module digit_cmp: purely combinational 4-bit-in, {eq,gt,lt}-out slice, correct for all 16 inputs.
- The slice is instantiated once in SCAN datapath.

Test Plan:
- Reset: hold reset_n low 3 cycles, release -> start_ready = 1, done_valid = 0, busy = 0, eq/gt/lt = 000.
- Equal operands: WIDTH = 16, a = b = 0x1234 -> eq = 1 with done_valid 9 cycles after accept, in both macro settings.
- Early exit, MSB digit differs: a = 0x8000, b = 0x7FFF.
  - SIGNED = 0 -> gt, done_valid 2 cycles after accept with EARLY_EXIT_EN; 9 cycles without.
  - SIGNED = 1 -> lt.
- LSB-only difference: a = 0x0002, b = 0x0001 -> gt; then swap operands -> lt. Both at 9 cycles. Checks the slice "10 vs 01" encoding.
- Backpressure: result a = 0x00F0, b = 0x0100 -> lt; hold done_ready = 0 for 5 cycles.
  - done_valid and lt stay stable; start_ready = 0.
  - start_valid pulsed during the stall is not accepted.
  - Release done_ready -> IDLE next cycle.
- Reset mid-SCAN: assert reset_n low 3 cycles after accepting a = 0xFFFF, b = 0x0000 (EARLY_EXIT_EN undefined) -> outputs return to reset values immediately.
  - A new compare a = 0x0001, b = 0x0001 afterwards yields eq.
